// File: rtl/router_rx_port.sv
// router_rx_port -- serial packet receive port with an output byte FIFO.
//
// Each frame on the serial line carries a 4-bit destination address
// (LSB first), five pad cycles, and then data bits (LSB first). Data bits
// are only taken when valid_n is low. Every 8 bits form a byte, and each
// byte is pushed into a first-word-fall-through FIFO together with its
// address and start/end-of-packet flags. Errors are reported as a
// one-cycle pulse on err_o. err_code keeps the most recent cause.
//
// Ports
//   clock      : sole clock, all state updates on its rising edge
//   reset_n    : asynchronous active-low reset
//   din        : serial data bit
//   frame_n    : active-low frame, goes high on the last data bit
//   valid_n    : active-low data-bit qualifier
//   busy_n     : active-low "do not start a new frame" to the sender
//   pkt_da     : destination address of the FIFO head byte
//   pkt_data   : FIFO head byte
//   pkt_sop    : head byte is the first byte of its packet
//   pkt_eop    : head byte is the last byte of its packet
//   pkt_valid  : FIFO is non-empty
//   pkt_ready  : consumer takes the head byte when pkt_valid is also high
//   err_o      : one-cycle error pulse
//   err_code   : 1 = framing, 2 = partial byte, 3 = overflow
module router_rx_port #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       din,
  input  logic       frame_n,
  input  logic       valid_n,
  output logic       busy_n,
  output logic [3:0] pkt_da,
  output logic [7:0] pkt_data,
  output logic       pkt_sop,
  output logic       pkt_eop,
  output logic       pkt_valid,
  input  logic       pkt_ready,
  output logic       err_o,
  output logic [1:0] err_code
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] BUSY_CNT = CW'(FIFO_DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_PAD, S_DATA, S_DROP} state_t;

  typedef struct packed {
    logic [3:0] da;
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } entry_t;

  state_t        state_q, state_d;
  logic [3:0]    addr_q, addr_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          first_q, first_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          busy_n_q, busy_n_d;
  logic          err_o_q, err_o_d;
  logic [1:0]    err_code_q, err_code_d;
  entry_t        mem_q [FIFO_DEPTH];
  entry_t        head;
  entry_t        push_entry;
  logic          byte_done;
  logic          push;
  logic          pop;
  logic          full;

  assign pop  = (count_q != '0) && pkt_ready;
  assign full = (count_q == FULL_CNT);

  // Receive FSM. cnt_q is reused: address bit index in ADDR (1..3),
  // pad cycle count in PAD (0..4) and data bit index in DATA (0..7).
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    first_d    = first_q;
    byte_done  = 1'b0;
    err_o_d    = 1'b0;
    err_code_d = err_code_q;
    unique case (state_q)
      S_IDLE: begin
        if (!frame_n) begin
          addr_d  = {3'b000, din};
          cnt_d   = 3'd1;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (frame_n) begin
          err_o_d    = 1'b1;
          err_code_d = 2'd1;
          state_d    = S_IDLE;
        end else begin
          addr_d[cnt_q[1:0]] = din;
          if (cnt_q == 3'd3) begin
            cnt_d   = 3'd0;
            state_d = S_PAD;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      S_PAD: begin
        if (frame_n) begin
          err_o_d    = 1'b1;
          err_code_d = 2'd1;
          state_d    = S_IDLE;
        end else if (!valid_n) begin
          err_o_d    = 1'b1;
          err_code_d = 2'd1;
          state_d    = S_DROP;
        end else if (cnt_q == 3'd4) begin
          cnt_d   = 3'd0;
          first_d = 1'b1;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_DATA: begin
        if (!valid_n) begin
          shift_d[cnt_q] = din;
          if (cnt_q == 3'd7) begin
            byte_done = 1'b1;
            cnt_d     = 3'd0;
            // A pop in the same cycle frees the slot, so only a full FIFO
            // with no pop loses the byte.
            if (full && !pop) begin
              err_o_d    = 1'b1;
              err_code_d = 2'd3;
              state_d    = frame_n ? S_IDLE : S_DROP;
            end else begin
              first_d = 1'b0;
              if (frame_n) state_d = S_IDLE;
            end
          end else if (frame_n) begin
            err_o_d    = 1'b1;
            err_code_d = 2'd2;
            state_d    = S_IDLE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else if (frame_n) begin
          err_o_d    = 1'b1;
          err_code_d = 2'd1;
          state_d    = S_IDLE;
        end
      end
      S_DROP: begin
        if (frame_n) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping. The pushed byte includes this cycle's bit, so it is
  // taken from shift_d, and eop is the frame_n level of the final bit.
  always_comb begin
    push       = byte_done && !(full && !pop);
    push_entry = '{da: addr_q, data: shift_d, sop: first_q, eop: frame_n};
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    busy_n_d = !((count_d >= BUSY_CNT) || (state_d == S_DROP));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= 4'h0;
      cnt_q      <= 3'd0;
      shift_q    <= 8'h00;
      first_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      busy_n_q   <= 1'b1;
      err_o_q    <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      first_q    <= first_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      busy_n_q   <= busy_n_d;
      err_o_q    <= err_o_d;
      err_code_q <= err_code_d;
    end
  end

  // Storage needs no reset: the head outputs are forced to zero while the
  // FIFO is empty.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head      = mem_q[rd_ptr_q];
  assign pkt_valid = (count_q != '0);
  assign pkt_da    = pkt_valid ? head.da   : 4'h0;
  assign pkt_data  = pkt_valid ? head.data : 8'h00;
  assign pkt_sop   = pkt_valid ? head.sop  : 1'b0;
  assign pkt_eop   = pkt_valid ? head.eop  : 1'b0;
  assign busy_n    = busy_n_q;
  assign err_o     = err_o_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_router_rx_port.sv
// Testbench for router_rx_port: a packet-level reference model predicts
// FIFO contents, busy_n and error reporting every cycle, and directed
// packets are checked against hand-computed byte/error lists.
module tb_router_rx_port;

  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       din;
  logic       frame_n;
  logic       valid_n;
  logic       busy_n;
  logic [3:0] pkt_da;
  logic [7:0] pkt_data;
  logic       pkt_sop;
  logic       pkt_eop;
  logic       pkt_valid;
  logic       pkt_ready;
  logic       err_o;
  logic [1:0] err_code;

  router_rx_port #(.FIFO_DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .din       (din),
    .frame_n   (frame_n),
    .valid_n   (valid_n),
    .busy_n    (busy_n),
    .pkt_da    (pkt_da),
    .pkt_data  (pkt_data),
    .pkt_sop   (pkt_sop),
    .pkt_eop   (pkt_eop),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .err_o     (err_o),
    .err_code  (err_code)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] da;
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } byte_t;

  int n_checks = 0;
  int n_fail   = 0;

  byte_t      out_log[$];
  logic [1:0] err_log[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expectByte(input string name, input int idx, input byte_t exp);
    if (idx < out_log.size()) begin
      checkOutput(name, 32'(out_log[idx]), 32'(exp));
    end else begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s: actual=missing required=%0h", name, exp);
    end
  endtask

  // Reference model: tracks the position within the current frame as a
  // plain cycle counter (1..3 address, 4..8 pad, 9 = data phase), a bit
  // counter for the byte being assembled, and a queue standing in for the
  // FIFO.
  byte_t      m_q[$];
  bit         m_inframe = 0;
  bit         m_drop    = 0;
  int         m_pos     = 0;
  int         m_nbits   = 0;
  logic [7:0] m_acc     = 8'h00;
  logic [3:0] m_addr    = 4'h0;
  bit         m_first   = 0;
  bit         m_err     = 0;
  logic [1:0] m_code    = 2'd0;
  bit         m_busy    = 1;
  bit         m_pop;
  bit         m_push;
  byte_t      m_new;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete();
      m_inframe = 0;
      m_drop    = 0;
      m_pos     = 0;
      m_nbits   = 0;
      m_err     = 0;
      m_code    = 2'd0;
      m_busy    = 1;
    end else begin
      m_pop  = (m_q.size() > 0) && pkt_ready;
      m_push = 0;
      m_err  = 0;
      if (m_drop) begin
        if (frame_n) m_drop = 0;
      end else if (!m_inframe) begin
        if (!frame_n) begin
          m_inframe = 1;
          m_addr    = {3'b000, din};
          m_pos     = 1;
        end
      end else if (m_pos < 4) begin
        if (frame_n) begin
          m_err = 1; m_code = 2'd1; m_inframe = 0;
        end else begin
          m_addr[m_pos] = din;
          m_pos++;
        end
      end else if (m_pos < 9) begin
        if (frame_n) begin
          m_err = 1; m_code = 2'd1; m_inframe = 0;
        end else if (!valid_n) begin
          m_err = 1; m_code = 2'd1; m_inframe = 0; m_drop = 1;
        end else begin
          m_pos++;
          if (m_pos == 9) begin
            m_nbits = 0;
            m_first = 1;
          end
        end
      end else begin
        if (!valid_n) begin
          m_acc[m_nbits] = din;
          m_nbits++;
          if (m_nbits == 8) begin
            m_nbits = 0;
            if (m_q.size() == DEPTH && !m_pop) begin
              m_err = 1; m_code = 2'd3; m_inframe = 0;
              m_drop = !frame_n;
            end else begin
              m_push  = 1;
              m_new   = byte_t'({m_addr, m_acc, m_first, frame_n});
              m_first = 0;
              if (frame_n) m_inframe = 0;
            end
          end else if (frame_n) begin
            m_err = 1; m_code = 2'd2; m_inframe = 0;
          end
        end else if (frame_n) begin
          m_err = 1; m_code = 2'd1; m_inframe = 0;
        end
      end
      if (m_pop) void'(m_q.pop_front());
      if (m_push) m_q.push_back(m_new);
      m_busy = !((m_q.size() >= DEPTH - 1) || m_drop);
    end
  end

  // Every-cycle comparison against the model, plus logging of consumed
  // bytes and error pulses for the per-test literal checks.
  always @(negedge clock) begin
    checkOutput("pkt_valid", 32'(pkt_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      checkOutput("pkt_da",   32'(pkt_da),   32'(m_q[0].da));
      checkOutput("pkt_data", 32'(pkt_data), 32'(m_q[0].data));
      checkOutput("pkt_sop",  32'(pkt_sop),  32'(m_q[0].sop));
      checkOutput("pkt_eop",  32'(pkt_eop),  32'(m_q[0].eop));
    end
    checkOutput("busy_n",   32'(busy_n),   32'(m_busy));
    checkOutput("err_o",    32'(err_o),    32'(m_err));
    checkOutput("err_code", 32'(err_code), 32'(m_code));
    if (pkt_valid && pkt_ready) out_log.push_back(byte_t'({pkt_da, pkt_data, pkt_sop, pkt_eop}));
    if (err_o) err_log.push_back(err_code);
  end

  // One serial cycle: inputs change 2 time units after a rising edge and
  // are sampled on the next one.
  task automatic applyStimulus(input logic f, input logic v, input logic d);
    frame_n = f;
    valid_n = v;
    din     = d;
    @(posedge clock);
    #2;
  endtask

  // Sends one frame. Stalls of 3 cycles follow data bit numbers stall_a and
  // stall_b (1-based, 0 = none); bad_pad puts valid_n low on that pad cycle;
  // abort_after stops after that many data bits with frame_n still low.
  task automatic sendFrame(input logic [3:0] addr, input logic [63:0] data, input int nbits,
                           input int stall_a, input int stall_b, input int bad_pad,
                           input int abort_after, input int gap);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, addr[i]);
    for (int p = 1; p <= 5; p++) applyStimulus(1'b0, (p == bad_pad) ? 1'b0 : 1'b1, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      if (abort_after > 0 && i == abort_after) return;
      applyStimulus((i == nbits - 1) ? 1'b1 : 1'b0, 1'b0, data[i]);
      if (i + 1 == stall_a || i + 1 == stall_b) begin
        for (int s = 0; s < 3; s++) applyStimulus(1'b0, 1'b1, 1'b0);
      end
    end
    for (int g = 0; g < gap; g++) applyStimulus(1'b1, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b1, 1'b0);
  endtask

  task automatic clearLogs();
    out_log.delete();
    err_log.delete();
  endtask

  initial begin
    reset_n   = 1'b1;
    frame_n   = 1'b1;
    valid_n   = 1'b1;
    din       = 1'b0;
    pkt_ready = 1'b1;
    #1 reset_n = 1'b0;
    @(posedge clock); @(posedge clock); #2;

    $display("[TB] reset values");
    checkOutput("rst pkt_valid", 32'(pkt_valid), 0);
    checkOutput("rst pkt_da",    32'(pkt_da),    0);
    checkOutput("rst pkt_data",  32'(pkt_data),  0);
    checkOutput("rst pkt_sop",   32'(pkt_sop),   0);
    checkOutput("rst pkt_eop",   32'(pkt_eop),   0);
    checkOutput("rst busy_n",    32'(busy_n),    1);
    checkOutput("rst err_o",     32'(err_o),     0);
    checkOutput("rst err_code",  32'(err_code),  0);
    reset_n = 1'b1;
    idle(2);

    $display("[TB] basic two-byte packet");
    clearLogs();
    sendFrame(4'hA, 64'h813C, 16, 0, 0, 0, 0, 3);
    idle(4);
    checkOutput("t1 bytes", out_log.size(), 2);
    expectByte("t1 byte0", 0, byte_t'({4'hA, 8'h3C, 1'b1, 1'b0}));
    expectByte("t1 byte1", 1, byte_t'({4'hA, 8'h81, 1'b0, 1'b1}));
    checkOutput("t1 errs", err_log.size(), 0);

    $display("[TB] same packet with stalls");
    clearLogs();
    sendFrame(4'hA, 64'h813C, 16, 2, 9, 0, 0, 3);
    idle(4);
    checkOutput("t2 bytes", out_log.size(), 2);
    expectByte("t2 byte0", 0, byte_t'({4'hA, 8'h3C, 1'b1, 1'b0}));
    expectByte("t2 byte1", 1, byte_t'({4'hA, 8'h81, 1'b0, 1'b1}));
    checkOutput("t2 errs", err_log.size(), 0);

    $display("[TB] overflow with consumer stalled");
    clearLogs();
    pkt_ready = 1'b0;
    sendFrame(4'h7, 64'h0000_6655_4433_2211, 48, 0, 0, 0, 0, 2);
    checkOutput("t3 errs", err_log.size(), 1);
    checkOutput("t3 code", (err_log.size() > 0) ? 32'(err_log[0]) : 32'hF, 3);
    checkOutput("t3 busy_n", 32'(busy_n), 0);
    checkOutput("t3 head data", 32'(pkt_data), 32'h11);
    checkOutput("t3 head sop", 32'(pkt_sop), 1);
    pkt_ready = 1'b1;
    idle(8);
    checkOutput("t3 bytes", out_log.size(), 4);
    expectByte("t3 byte0", 0, byte_t'({4'h7, 8'h11, 1'b1, 1'b0}));
    expectByte("t3 byte1", 1, byte_t'({4'h7, 8'h22, 1'b0, 1'b0}));
    expectByte("t3 byte2", 2, byte_t'({4'h7, 8'h33, 1'b0, 1'b0}));
    expectByte("t3 byte3", 3, byte_t'({4'h7, 8'h44, 1'b0, 1'b0}));
    checkOutput("t3 busy_n after drain", 32'(busy_n), 1);

    $display("[TB] bad pad then back-to-back good packets");
    clearLogs();
    sendFrame(4'h3, 64'h55, 8, 0, 0, 3, 0, 1);
    sendFrame(4'h5, 64'hC3, 8, 0, 0, 0, 0, 0);
    sendFrame(4'h6, 64'h7E, 8, 0, 0, 0, 0, 4);
    checkOutput("t4 errs", err_log.size(), 1);
    checkOutput("t4 code", (err_log.size() > 0) ? 32'(err_log[0]) : 32'hF, 1);
    checkOutput("t4 bytes", out_log.size(), 2);
    expectByte("t4 byte0", 0, byte_t'({4'h5, 8'hC3, 1'b1, 1'b1}));
    expectByte("t4 byte1", 1, byte_t'({4'h6, 8'h7E, 1'b1, 1'b1}));

    $display("[TB] partial trailing byte");
    clearLogs();
    sendFrame(4'h9, 64'hABC, 12, 0, 0, 0, 0, 4);
    checkOutput("t5 bytes", out_log.size(), 1);
    expectByte("t5 byte0", 0, byte_t'({4'h9, 8'hBC, 1'b1, 1'b0}));
    checkOutput("t5 errs", err_log.size(), 1);
    checkOutput("t5 code", (err_log.size() > 0) ? 32'(err_log[0]) : 32'hF, 2);
    checkOutput("t5 code held", 32'(err_code), 2);

    $display("[TB] asynchronous reset mid-byte");
    clearLogs();
    pkt_ready = 1'b0;
    sendFrame(4'hE, 64'h123456, 24, 0, 0, 0, 20, 0);
    checkOutput("t6 pre valid", 32'(pkt_valid), 1);
    checkOutput("t6 pre data", 32'(pkt_data), 32'h56);
    #4 reset_n = 1'b0;
    #1;
    checkOutput("t6 rst pkt_valid", 32'(pkt_valid), 0);
    checkOutput("t6 rst pkt_data",  32'(pkt_data),  0);
    checkOutput("t6 rst pkt_da",    32'(pkt_da),    0);
    checkOutput("t6 rst pkt_sop",   32'(pkt_sop),   0);
    checkOutput("t6 rst busy_n",    32'(busy_n),    1);
    checkOutput("t6 rst err_code",  32'(err_code),  0);
    @(posedge clock); #2;
    idle(2);
    reset_n   = 1'b1;
    pkt_ready = 1'b1;
    sendFrame(4'h2, 64'h96, 8, 0, 0, 0, 0, 4);
    checkOutput("t6 bytes", out_log.size(), 1);
    expectByte("t6 byte0", 0, byte_t'({4'h2, 8'h96, 1'b1, 1'b1}));
    checkOutput("t6 errs", err_log.size(), 0);

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
